// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  localparam int DIV_W = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_restore_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, select.
import div_pkg::*;

module restore_step #(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] trial;

  always_comb begin
    r_shift = {r, q[WIDTH-1]};
    trial   = r_shift - {1'b0, d};
    // A clear borrow bit means the divisor fit: keep the difference and emit a 1.
    if (!trial[WIDTH]) begin
      r_next = trial[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      r_next = r_shift[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, Start/Busy/Done handshake.
// state | meaning
// IDLE  | waiting for Start
// RUN   | WIDTH restoring steps in progress
// DONE  | one-cycle result pulse; Start here begins the next operation
import div_pkg::*;

module seq_divider #(
  parameter int WIDTH = DIV_W
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_t       state, state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] r_reg, q_reg, d_reg;
  logic [WIDTH-1:0] r_next, q_next;
  logic             accept, div_by_zero, last_step;

  assign accept      = Start && ((state == IDLE) || (state == DONE));
  assign div_by_zero = (Divisor == '0);
  assign last_step   = (state == RUN) && (count == CNT_W'(WIDTH - 1));

  restore_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .d      (d_reg),
    .r_next (r_next),
    .q_next (q_next)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (Start) state_next = div_by_zero ? DONE : RUN;
        else       state_next = IDLE;
      end
      RUN:     if (last_step) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == RUN);
    Done = (state == DONE);
  end

  // Result registers only move at completion or on a divide-by-zero accept, never mid-run.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      count     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivZero   <= 1'b0;
    end else if (accept) begin
      d_reg <= Divisor;
      if (div_by_zero) begin
        Quotient  <= '1;
        Remainder <= Dividend;
        DivZero   <= 1'b1;
      end else begin
        r_reg   <= '0;
        q_reg   <= Dividend;
        count   <= '0;
        DivZero <= 1'b0;
      end
    end else if (state == RUN) begin
      r_reg <= r_next;
      q_reg <= q_next;
      count <= count + CNT_W'(1);
      if (last_step) begin
        Quotient  <= q_next;
        Remainder <= r_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vectors, handshake corner cases, random sweep.
module tb_seq_divider;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] Dividend = '0;
  logic [W-1:0] Divisor = '0;
  logic         Busy, Done, DivZero;
  logic [W-1:0] Quotient, Remainder;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;

  seq_divider #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero),
    .Quotient  (Quotient),
    .Remainder (Remainder)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (Done) done_seen++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Returns at the falling edge that follows the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clk);
    Start    = 1'b1;
    Dividend = a;
    Divisor  = b;
    @(negedge Clk);
    Start    = 1'b0;
    Dividend = W'($urandom);
    Divisor  = W'($urandom);
  endtask

  // edges counts clock edges from the accept edge up to the one that raised Done.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 1;
    busy_cycles = 0;
    while (!Done && edges < 20) begin
      if (Busy) busy_cycles++;
      @(negedge Clk);
      edges++;
    end
  endtask

  initial begin
    int edges, busy_cycles, accepts, done_base, quiet;
    logic [W-1:0] a, b, exp_q, exp_r;

    vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,  dz: 1'b0, lat: 9};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dz: 1'b0, lat: 9};
    vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  dz: 1'b0, lat: 9};
    vecs[3] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,  dz: 1'b0, lat: 9};
    vecs[4] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dz: 1'b0, lat: 9};
    vecs[5] = '{a: 8'd77,  b: 8'd0,   q: 8'd255, r: 8'd77, dz: 1'b1, lat: 1};

    @(negedge Clk);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_divzero", DivZero, 0);
    chk("reset_quotient", Quotient, 0);
    chk("reset_remainder", Remainder, 0);
    Reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(edges, busy_cycles);
      chk($sformatf("vec%0d_latency", i), edges, vecs[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), busy_cycles, vecs[i].lat - 1);
      chk($sformatf("vec%0d_quotient", i), Quotient, vecs[i].q);
      chk($sformatf("vec%0d_remainder", i), Remainder, vecs[i].r);
      chk($sformatf("vec%0d_divzero", i), DivZero, vecs[i].dz);
      @(negedge Clk);
      chk($sformatf("vec%0d_done_pulse_width", i), Done, 0);
    end

    // Start during RUN is ignored, then back-to-back accept from DONE.
    start_op(8'd200, 8'd3);
    repeat (3) @(negedge Clk);
    Start = 1'b1; Dividend = 8'd9; Divisor = 8'd2;
    @(negedge Clk);
    Start = 1'b0;
    wait_done(edges, busy_cycles);
    chk("ignore_start_quotient", Quotient, 66);
    chk("ignore_start_remainder", Remainder, 2);
    Start = 1'b1; Dividend = 8'd9; Divisor = 8'd2;
    @(negedge Clk);
    Start = 1'b0;
    chk("b2b_done_single_pulse", Done, 0);
    chk("b2b_busy", Busy, 1);
    chk("b2b_quotient_held", Quotient, 66);
    wait_done(edges, busy_cycles);
    chk("b2b_latency", edges, 9);
    chk("b2b_quotient", Quotient, 4);
    chk("b2b_remainder", Remainder, 1);

    // Asynchronous reset mid-run.
    start_op(8'd100, 8'd7);
    repeat (4) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_busy", Busy, 0);
    chk("async_rst_done", Done, 0);
    chk("async_rst_quotient", Quotient, 0);
    chk("async_rst_remainder", Remainder, 0);
    quiet = 0;
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (12) begin
      @(negedge Clk);
      if (Done || Busy) quiet++;
    end
    chk("async_rst_no_done", quiet, 0);
    start_op(8'd100, 8'd7);
    wait_done(edges, busy_cycles);
    chk("post_rst_latency", edges, 9);
    chk("post_rst_quotient", Quotient, 14);
    chk("post_rst_remainder", Remainder, 2);
    @(negedge Clk);

    // Random sweep against plain arithmetic.
    done_base = done_seen;
    accepts = 0;
    for (int k = 0; k < 3000; k++) begin
      a = W'($urandom_range(255, 0));
      b = ($urandom_range(15, 0) == 0) ? 8'd0 : W'($urandom_range(255, 0));
      if (b == 0) begin
        exp_q = 8'd255;
        exp_r = a;
      end else begin
        exp_q = a / b;
        exp_r = a % b;
      end
      start_op(a, b);
      accepts++;
      wait_done(edges, busy_cycles);
      chk($sformatf("rnd_latency %0d/%0d", a, b), edges, (b == 0) ? 1 : 9);
      chk($sformatf("rnd_quotient %0d/%0d", a, b), Quotient, exp_q);
      chk($sformatf("rnd_remainder %0d/%0d", a, b), Remainder, exp_r);
      chk($sformatf("rnd_divzero %0d/%0d", a, b), DivZero, (b == 0) ? 1 : 0);
      if (b != 0) begin
        chk($sformatf("rnd_invariant %0d/%0d", a, b),
            (int'(Quotient) * int'(b) + int'(Remainder) == int'(a)) && (Remainder < b), 1);
      end
      if ($urandom_range(1, 0) == 1) @(negedge Clk);
    end
    @(negedge Clk);
    chk("rnd_done_count", done_seen - done_base, accepts);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
